// File: rtl/dual_chan_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// dual_chan_deserializer_pkg
// Shared definitions for the dual-channel deserializer:
//   DEFAULT_WIDTH : default bits per assembled word
//   N_CHAN        : number of deserializer channels
//   lane_state_t  : holding FSM state of one lane (EMPTY, FULL)
//   cnt_width()   : bit counter width needed for a given word width
// -----------------------------------------------------------------------------
package dual_chan_deserializer_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int N_CHAN        = 2;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } lane_state_t;

   // Counter has to count 0..w-1; a 2-bit word still needs a 1-bit counter.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/dual_chan_deserializer_lane.sv
// -----------------------------------------------------------------------------
// deser_lane
// One deserializer lane: MSB-first shift register, bit counter and a
// two-state holding register with a valid/ready output handshake.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   bit_valid  : a serial bit for this lane is present this cycle
//   bit_in     : the serial bit
//   out_data   : held word (stable while out_valid=1 and out_ready=0)
//   out_valid  : held word not yet delivered
//   out_ready  : consumer accepts the held word
//   ovf        : one-cycle pulse, a completed word was dropped
// -----------------------------------------------------------------------------
module deser_lane
   import dual_chan_deserializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ovf
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] r_shift;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hold;
   logic             r_ovf;
   lane_state_t      r_state;

   lane_state_t      w_state_next;
   logic             w_complete;
   logic             w_load;
   logic             w_drop;
   logic [WIDTH-1:0] w_word;

   // The word as it will look once the current bit is shifted in; used both
   // for the shift register update and for loading the holding register on
   // the completing bit, so the completed word is visible one cycle later.
   assign w_word     = {r_shift[WIDTH-2:0], bit_in};
   assign w_complete = bit_valid && (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_drop       = 1'b0;
      case (r_state)
         EMPTY: begin
            // out_ready has no meaning while nothing is held.
            if (w_complete) begin
               w_load       = 1'b1;
               w_state_next = FULL;
            end
         end
         FULL: begin
            if (out_ready) begin
               // Old word leaves this cycle; a word completing in the same
               // cycle replaces it with no bubble on out_valid.
               if (w_complete) begin
                  w_load = 1'b1;
               end else begin
                  w_state_next = EMPTY;
               end
            end else if (w_complete) begin
               // Holding register is occupied and not draining: the new
               // word is lost and the held word is left untouched.
               w_drop = 1'b1;
            end
         end
         default: begin
            w_state_next = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_hold  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (bit_valid) begin
            r_shift <= w_word;
            r_cnt   <= w_complete ? '0 : r_cnt + 1'b1;
         end
         if (w_load) begin
            r_hold <= w_word;
         end
         r_ovf <= w_drop;
      end
   end

   assign out_data  = r_hold;
   assign out_valid = (r_state == FULL);
   assign ovf       = r_ovf;

endmodule

// File: rtl/dual_chan_deserializer.sv
// -----------------------------------------------------------------------------
// dual_chan_deserializer
// Reassembles words from the two outputs of an upstream 1:2 serial demux.
// Each strobed bit goes to the lane picked by in_sel; both lanes run
// independently and deliver words through their own valid/ready handshake.
// Ports:
//   clk, rst_n            : clock (rising edge) and synchronous active-low reset
//   in_valid              : qualifies in_sel/y0/y1 for one cycle
//   in_sel                : 0 = channel 0 (y0), 1 = channel 1 (y1)
//   y0, y1                : demux outputs for channel 0 / channel 1
//   outN_data/valid/ready : assembled word handshake for channel N
//   ovf0, ovf1            : one-cycle pulse, a completed word was dropped
//   sel_err               : one-cycle pulse, the non-selected y input was 1
// -----------------------------------------------------------------------------
module dual_chan_deserializer
   import dual_chan_deserializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_sel,
   input  logic             y0,
   input  logic             y1,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic             ovf0,
   output logic             ovf1,
   output logic             sel_err
);

   logic [N_CHAN-1:0] w_bit_valid;
   logic [N_CHAN-1:0] w_bit_in;
   logic [N_CHAN-1:0] w_ready;
   logic [N_CHAN-1:0] w_valid;
   logic [N_CHAN-1:0] w_ovf;
   logic [WIDTH-1:0]  w_data [N_CHAN];
   logic              r_sel_err;

   assign w_bit_valid = {in_valid & in_sel, in_valid & ~in_sel};
   assign w_bit_in    = {y1, y0};
   assign w_ready     = {out1_ready, out0_ready};

   generate
      for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_lane
         deser_lane #(
            .WIDTH (WIDTH)
         ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .bit_valid (w_bit_valid[gi]),
            .bit_in    (w_bit_in[gi]),
            .out_data  (w_data[gi]),
            .out_valid (w_valid[gi]),
            .out_ready (w_ready[gi]),
            .ovf       (w_ovf[gi])
         );
      end
   endgenerate

   // A 1 on the idle demux leg means the upstream demux and in_sel disagree.
   // The selected bit is still taken; this only flags the condition.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sel_err <= 1'b0;
      end else begin
         r_sel_err <= in_valid & (in_sel ? y0 : y1);
      end
   end

   assign out0_data  = w_data[0];
   assign out0_valid = w_valid[0];
   assign out1_data  = w_data[1];
   assign out1_valid = w_valid[1];
   assign ovf0       = w_ovf[0];
   assign ovf1       = w_ovf[1];
   assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_dual_chan_deserializer.sv
// -----------------------------------------------------------------------------
// tb_dual_chan_deserializer
// Directed bench for dual_chan_deserializer (WIDTH = 8). Inputs change on the
// falling clock edge; outputs are read on the falling edge (or 2 time units
// after it in the monitor), well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_dual_chan_deserializer;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       in_valid   = 1'b0;
   logic       in_sel     = 1'b0;
   logic       y0         = 1'b0;
   logic       y1         = 1'b0;
   logic       out0_ready = 1'b0;
   logic       out1_ready = 1'b0;
   logic [7:0] out0_data;
   logic [7:0] out1_data;
   logic       out0_valid;
   logic       out1_valid;
   logic       ovf0;
   logic       ovf1;
   logic       sel_err;

   int n_vec = 0;
   int n_err = 0;

   // Monitor state, written only by the monitor process.
   int         cyc         = 0;
   int         ovf0_cnt    = 0;
   int         ovf1_cnt    = 0;
   int         sel_err_cnt = 0;
   logic [7:0] xfer0_q[$];
   logic [7:0] xfer1_q[$];
   int         xfer0_cyc[$];

   dual_chan_deserializer #(
      .WIDTH (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_sel     (in_sel),
      .y0         (y0),
      .y1         (y1),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .ovf0       (ovf0),
      .ovf1       (ovf1),
      .sel_err    (sel_err)
   );

   always #5 clk = ~clk;

   // Handshakes are recorded from the values that the next rising edge will see.
   always @(negedge clk) begin
      #2;
      cyc++;
      if (ovf0)    ovf0_cnt++;
      if (ovf1)    ovf1_cnt++;
      if (sel_err) sel_err_cnt++;
      if (rst_n && out0_valid && out0_ready) begin
         xfer0_q.push_back(out0_data);
         xfer0_cyc.push_back(cyc);
      end
      if (rst_n && out1_valid && out1_ready) begin
         xfer1_q.push_back(out1_data);
      end
   end

   task automatic send_bit(input logic sel, input logic b);
      @(negedge clk);
      in_valid = 1'b1;
      in_sel   = sel;
      y0       = sel ? 1'b0 : b;
      y1       = sel ? b : 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         y0       = 1'b0;
         y1       = 1'b0;
      end
   endtask

   task automatic send_word(input logic sel, input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(sel, w[i]);
   endtask

   task automatic consume(input logic sel);
      @(negedge clk);
      in_valid = 1'b0;
      if (sel) out1_ready = 1'b1;
      else     out0_ready = 1'b1;
      @(negedge clk);
      out0_ready = 1'b0;
      out1_ready = 1'b0;
   endtask

   task automatic test_reset;
      // Stimulus during reset must be ignored.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      y0       = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({out0_data, out1_data} !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_data: got %h/%h expected 00/00", out0_data, out1_data);
      end
      n_vec++;
      if ({out0_valid, out1_valid, ovf0, ovf1, sel_err} !== 5'b00000) begin
         n_err++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {out0_valid, out1_valid, ovf0, ovf1, sel_err});
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      y0       = 1'b0;
      idle(1);
   endtask

   task automatic test_chan0_word;
      logic [7:0] w;
      w = 8'hB2;
      for (int i = 7; i >= 1; i--) send_bit(1'b0, w[i]);
      send_bit(1'b0, w[0]);
      n_vec++;
      if (out0_valid !== 1'b0) begin
         n_err++;
         $display("FAIL ch0_early_valid: got %b expected 0", out0_valid);
      end
      idle(1);
      n_vec++;
      if (out0_valid !== 1'b1 || out0_data !== 8'hB2) begin
         n_err++;
         $display("FAIL ch0_word: got valid=%b data=%h expected valid=1 data=b2",
                  out0_valid, out0_data);
      end
      n_vec++;
      if (out1_valid !== 1'b0) begin
         n_err++;
         $display("FAIL ch0_word_ch1_quiet: got %b expected 0", out1_valid);
      end
      idle(2);
      n_vec++;
      if (out0_valid !== 1'b1 || out0_data !== 8'hB2) begin
         n_err++;
         $display("FAIL ch0_hold_stable: got valid=%b data=%h expected valid=1 data=b2",
                  out0_valid, out0_data);
      end
      consume(1'b0);
      n_vec++;
      if (out0_valid !== 1'b0 || xfer0_q.size() == 0 || xfer0_q[$] !== 8'hB2) begin
         n_err++;
         $display("FAIL ch0_transfer: got valid=%b xfers=%0d expected valid=0 last=b2",
                  out0_valid, xfer0_q.size());
      end
   endtask

   task automatic test_interleave;
      logic [7:0] a;
      logic [7:0] c;
      a = 8'hA5;
      c = 8'h3C;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b0, a[i]);
         send_bit(1'b1, c[i]);
      end
      idle(1);
      n_vec++;
      if (out0_valid !== 1'b1 || out0_data !== 8'hA5) begin
         n_err++;
         $display("FAIL interleave_ch0: got valid=%b data=%h expected valid=1 data=a5",
                  out0_valid, out0_data);
      end
      n_vec++;
      if (out1_valid !== 1'b1 || out1_data !== 8'h3C) begin
         n_err++;
         $display("FAIL interleave_ch1: got valid=%b data=%h expected valid=1 data=3c",
                  out1_valid, out1_data);
      end
      @(negedge clk);
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      @(negedge clk);
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      n_vec++;
      if ({out0_valid, out1_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL interleave_drain: got %b expected 00", {out0_valid, out1_valid});
      end
   endtask

   task automatic test_overflow;
      int ovf_base;
      int ovf0_base;
      int q_base;
      ovf_base   = ovf1_cnt;
      ovf0_base  = ovf0_cnt;
      q_base     = xfer1_q.size();
      out1_ready = 1'b0;
      send_word(1'b1, 8'h01);
      send_word(1'b1, 8'hFF);
      idle(1);
      n_vec++;
      if (ovf1 !== 1'b1) begin
         n_err++;
         $display("FAIL ovf1_pulse: got %b expected 1", ovf1);
      end
      n_vec++;
      if (out1_valid !== 1'b1 || out1_data !== 8'h01) begin
         n_err++;
         $display("FAIL ovf_held_word: got valid=%b data=%h expected valid=1 data=01",
                  out1_valid, out1_data);
      end
      idle(2);
      n_vec++;
      if (ovf1_cnt - ovf_base != 1 || ovf0_cnt != ovf0_base) begin
         n_err++;
         $display("FAIL ovf_count: got ovf1=%0d ovf0=%0d expected ovf1=1 ovf0=0",
                  ovf1_cnt - ovf_base, ovf0_cnt - ovf0_base);
      end
      consume(1'b1);
      idle(3);
      n_vec++;
      if (out1_valid !== 1'b0 || xfer1_q.size() - q_base != 1) begin
         n_err++;
         $display("FAIL ovf_drain: got valid=%b xfers=%0d expected valid=0 xfers=1",
                  out1_valid, xfer1_q.size() - q_base);
      end else if (xfer1_q[$] !== 8'h01) begin
         n_vec++;
         n_err++;
         $display("FAIL ovf_drain_data: got %h expected 01", xfer1_q[$]);
      end
   endtask

   task automatic test_back_to_back;
      int         q_base;
      logic [7:0] exp_w [3];
      exp_w[0]   = 8'h5A;
      exp_w[1]   = 8'hC3;
      exp_w[2]   = 8'h96;
      q_base     = xfer0_q.size();
      out0_ready = 1'b1;
      for (int k = 0; k < 3; k++) send_word(1'b0, exp_w[k]);
      idle(2);
      out0_ready = 1'b0;
      n_vec++;
      if (xfer0_q.size() - q_base != 3) begin
         n_err++;
         $display("FAIL b2b_count: got %0d words expected 3", xfer0_q.size() - q_base);
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (xfer0_q[q_base + k] !== exp_w[k]) begin
               n_err++;
               $display("FAIL b2b_word%0d: got %h expected %h", k, xfer0_q[q_base + k], exp_w[k]);
            end
         end
         for (int k = 1; k < 3; k++) begin
            n_vec++;
            if (xfer0_cyc[q_base + k] - xfer0_cyc[q_base + k - 1] != 8) begin
               n_err++;
               $display("FAIL b2b_spacing%0d: got %0d cycles expected 8", k,
                        xfer0_cyc[q_base + k] - xfer0_cyc[q_base + k - 1]);
            end
         end
      end
   endtask

   task automatic test_no_bubble;
      logic [7:0] w;
      int         ovf_base;
      int         q_base;
      ovf_base = ovf0_cnt;
      w        = 8'h22;
      send_word(1'b0, 8'h11);
      idle(1);
      q_base = xfer0_q.size();
      for (int i = 7; i >= 1; i--) send_bit(1'b0, w[i]);
      // Ready coincides with the completing bit of the next word.
      @(negedge clk);
      in_valid   = 1'b1;
      in_sel     = 1'b0;
      y0         = w[0];
      out0_ready = 1'b1;
      @(negedge clk);
      in_valid   = 1'b0;
      y0         = 1'b0;
      out0_ready = 1'b0;
      n_vec++;
      if (out0_valid !== 1'b1 || out0_data !== 8'h22) begin
         n_err++;
         $display("FAIL nobubble_word: got valid=%b data=%h expected valid=1 data=22",
                  out0_valid, out0_data);
      end
      n_vec++;
      if (xfer0_q.size() - q_base != 1 || ovf0_cnt != ovf_base) begin
         n_err++;
         $display("FAIL nobubble_xfer: got xfers=%0d ovf=%0d expected xfers=1 ovf=0",
                  xfer0_q.size() - q_base, ovf0_cnt - ovf_base);
      end else if (xfer0_q[$] !== 8'h11) begin
         n_vec++;
         n_err++;
         $display("FAIL nobubble_old: got %h expected 11", xfer0_q[$]);
      end
      consume(1'b0);
   endtask

   task automatic test_reset_midword;
      int ovf_base;
      int q_base;
      for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      y0       = 1'b1;
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      y0       = 1'b0;
      send_word(1'b0, 8'h0F);
      idle(1);
      n_vec++;
      if (out0_valid !== 1'b1 || out0_data !== 8'h0F) begin
         n_err++;
         $display("FAIL midword_reset: got valid=%b data=%h expected valid=1 data=0f",
                  out0_valid, out0_data);
      end
      // Reset while FULL drops the held word silently.
      ovf_base = ovf0_cnt;
      q_base   = xfer0_q.size();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      n_vec++;
      if (out0_valid !== 1'b0 || out0_data !== 8'h00 || ovf0_cnt != ovf_base ||
          xfer0_q.size() != q_base) begin
         n_err++;
         $display("FAIL full_reset: got valid=%b data=%h ovf=%0d xfers=%0d expected 0/00/0/0",
                  out0_valid, out0_data, ovf0_cnt - ovf_base, xfer0_q.size() - q_base);
      end
   endtask

   task automatic test_sel_err;
      int err_base;
      err_base = sel_err_cnt;
      @(negedge clk);
      in_valid = 1'b1;
      in_sel   = 1'b0;
      y0       = 1'b0;
      y1       = 1'b1;
      idle(1);
      n_vec++;
      if (sel_err !== 1'b1) begin
         n_err++;
         $display("FAIL sel_err_pulse0: got %b expected 1", sel_err);
      end
      idle(1);
      n_vec++;
      if (sel_err !== 1'b0) begin
         n_err++;
         $display("FAIL sel_err_width: got %b expected 0", sel_err);
      end
      // The flagged 0 bit was counted: seven more 1s complete 8'h7F.
      for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b1);
      idle(1);
      n_vec++;
      if (out0_valid !== 1'b1 || out0_data !== 8'h7F || out1_valid !== 1'b0) begin
         n_err++;
         $display("FAIL sel_err_counted: got v0=%b d0=%h v1=%b expected 1/7f/0",
                  out0_valid, out0_data, out1_valid);
      end
      consume(1'b0);
      // Mirror case on channel 1.
      @(negedge clk);
      in_valid = 1'b1;
      in_sel   = 1'b1;
      y0       = 1'b1;
      y1       = 1'b0;
      idle(1);
      n_vec++;
      if (sel_err !== 1'b1) begin
         n_err++;
         $display("FAIL sel_err_pulse1: got %b expected 1", sel_err);
      end
      for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1);
      idle(1);
      n_vec++;
      if (out1_valid !== 1'b1 || out1_data !== 8'h7F || sel_err_cnt - err_base != 2) begin
         n_err++;
         $display("FAIL sel_err_ch1: got v1=%b d1=%h errs=%0d expected 1/7f/2",
                  out1_valid, out1_data, sel_err_cnt - err_base);
      end
      consume(1'b1);
   endtask

   initial begin
      test_reset;
      test_chan0_word;
      test_interleave;
      test_overflow;
      test_back_to_back;
      test_no_bubble;
      test_reset_midword;
      test_sel_err;
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
